// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction handshake and decoded-control bundle for alu_issue_ctrl
interface alu_issue_ctrl_if;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic [2:0]  ALUOP;
    logic [2:0]  READREG1;
    logic [2:0]  READREG2;
    logic [2:0]  WRITEREG;
    logic [7:0]  IMMEDIATE;
    logic        IMM_SEL;
    logic        NEG_SEL;
    logic        WRITEENABLE;
    logic        JUMP;
    logic        BRANCH_TAKEN;
    logic        ILLEGAL;
    logic        BUSY;

    // master: the issue controller; slave: fetch plus ALU/register-file side
    modport master (
        input  INSTR_VALID, INSTRUCTION, ZERO,
        output INSTR_READY, ALUOP, READREG1, READREG2, WRITEREG, IMMEDIATE,
               IMM_SEL, NEG_SEL, WRITEENABLE, JUMP, BRANCH_TAKEN, ILLEGAL, BUSY
    );

    modport slave (
        output INSTR_VALID, INSTRUCTION, ZERO,
        input  INSTR_READY, ALUOP, READREG1, READREG2, WRITEREG, IMMEDIATE,
               IMM_SEL, NEG_SEL, WRITEENABLE, JUMP, BRANCH_TAKEN, ILLEGAL, BUSY
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - decodes one instruction, holds ALU controls for its latency, then resolves
module alu_issue_ctrl #(
    parameter int MULT_CYCLES  = 3,
    parameter int SHIFT_CYCLES = 2,
    parameter int BASIC_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    alu_issue_ctrl_if.master  bus
);

    localparam logic [7:0] MULT_LAT  = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] SHIFT_LAT = 8'(SHIFT_CYCLES - 1);
    localparam logic [7:0] BASIC_LAT = 8'(BASIC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESOLVE} state_t;

    state_t state, state_nxt;
    logic [7:0] cnt;
    logic       accept;

    logic [2:0] dec_aluop;
    logic       dec_imm_sel, dec_neg_sel, dec_wr, dec_beq, dec_bne, dec_j, dec_ill;
    logic [7:0] dec_imm, dec_lat;

    logic [2:0] aluop_q, rr1_q, rr2_q, wr_q;
    logic [7:0] imm_q;
    logic       imm_sel_q, neg_sel_q, wen_q, beq_q, bne_q, j_q, ill_q;

    logic       unused_instr_bits;
    assign unused_instr_bits = ^bus.INSTRUCTION[15:11];

    assign accept = bus.INSTR_VALID && (state == IDLE);

    always_comb begin
        dec_aluop   = 3'b000;
        dec_imm_sel = 1'b0;
        dec_neg_sel = 1'b0;
        dec_wr      = 1'b0;
        dec_beq     = 1'b0;
        dec_bne     = 1'b0;
        dec_j       = 1'b0;
        dec_ill     = 1'b0;
        dec_lat     = BASIC_LAT;
        dec_imm     = bus.INSTRUCTION[7:0];
        case (bus.INSTRUCTION[31:24])
            8'h00: begin dec_imm_sel = 1'b1; dec_wr = 1'b1; end
            8'h01: dec_wr = 1'b1;
            8'h02: begin dec_aluop = 3'b001; dec_wr = 1'b1; end
            8'h03: begin dec_aluop = 3'b001; dec_neg_sel = 1'b1; dec_wr = 1'b1; end
            8'h04: begin dec_aluop = 3'b010; dec_wr = 1'b1; end
            8'h05: begin dec_aluop = 3'b011; dec_wr = 1'b1; end
            8'h06: dec_j = 1'b1;
            // Branches carry their offset in the upper field so src2 stays free for the compare
            8'h07: begin
                dec_aluop = 3'b001; dec_neg_sel = 1'b1; dec_beq = 1'b1;
                dec_imm   = bus.INSTRUCTION[23:16];
            end
            8'h08: begin dec_aluop = 3'b111; dec_wr = 1'b1; dec_lat = MULT_LAT; end
            8'h09: begin dec_aluop = 3'b100; dec_imm_sel = 1'b1; dec_wr = 1'b1; dec_lat = SHIFT_LAT; end
            8'h0A: begin dec_aluop = 3'b101; dec_imm_sel = 1'b1; dec_wr = 1'b1; dec_lat = SHIFT_LAT; end
            8'h0B: begin dec_aluop = 3'b110; dec_imm_sel = 1'b1; dec_wr = 1'b1; dec_lat = SHIFT_LAT; end
            8'h0C: begin
                dec_aluop = 3'b001; dec_neg_sel = 1'b1; dec_bne = 1'b1;
                dec_imm   = bus.INSTRUCTION[23:16];
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = dec_ill ? RESOLVE : EXEC;
            EXEC:    if (cnt == 8'd0) state_nxt = RESOLVE;
            RESOLVE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt       <= 8'd0;
            aluop_q   <= 3'b000;
            rr1_q     <= 3'b000;
            rr2_q     <= 3'b000;
            wr_q      <= 3'b000;
            imm_q     <= 8'd0;
            imm_sel_q <= 1'b0;
            neg_sel_q <= 1'b0;
            wen_q     <= 1'b0;
            beq_q     <= 1'b0;
            bne_q     <= 1'b0;
            j_q       <= 1'b0;
            ill_q     <= 1'b0;
        end else if (accept) begin
            cnt       <= dec_lat;
            aluop_q   <= dec_aluop;
            rr1_q     <= bus.INSTRUCTION[10:8];
            rr2_q     <= bus.INSTRUCTION[2:0];
            wr_q      <= bus.INSTRUCTION[18:16];
            imm_q     <= dec_imm;
            imm_sel_q <= dec_imm_sel;
            neg_sel_q <= dec_neg_sel;
            wen_q     <= dec_wr;
            beq_q     <= dec_beq;
            bne_q     <= dec_bne;
            j_q       <= dec_j;
            ill_q     <= dec_ill;
        end else if (state == EXEC && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Strobes are masked by RESET so an instruction aborted in its resolve cycle never commits
    always_comb begin
        bus.INSTR_READY  = (state == IDLE);
        bus.BUSY         = (state != IDLE);
        bus.WRITEENABLE  = 1'b0;
        bus.JUMP         = 1'b0;
        bus.BRANCH_TAKEN = 1'b0;
        bus.ILLEGAL      = 1'b0;
        if (state == RESOLVE && !RESET) begin
            bus.WRITEENABLE  = wen_q;
            bus.JUMP         = j_q;
            bus.BRANCH_TAKEN = (beq_q && bus.ZERO) || (bne_q && !bus.ZERO);
            bus.ILLEGAL      = ill_q;
        end
    end

    assign bus.ALUOP     = aluop_q;
    assign bus.READREG1  = rr1_q;
    assign bus.READREG2  = rr2_q;
    assign bus.WRITEREG  = wr_q;
    assign bus.IMMEDIATE = imm_q;
    assign bus.IMM_SEL   = imm_sel_q;
    assign bus.NEG_SEL   = neg_sel_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.MULT_CYCLES(3), .SHIFT_CYCLES(2), .BASIC_CYCLES(1)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // ctrl = {ALUOP, READREG1, READREG2, WRITEREG, IMMEDIATE, IMM_SEL, NEG_SEL}
    // res  = {WRITEENABLE, JUMP, BRANCH_TAKEN, ILLEGAL} expected in the resolve cycle
    typedef struct {
        logic [21:0] ctrl;
        logic [3:0]  res;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;

    function automatic logic [21:0] ctrl_now();
        return {bus.ALUOP, bus.READREG1, bus.READREG2, bus.WRITEREG,
                bus.IMMEDIATE, bus.IMM_SEL, bus.NEG_SEL};
    endfunction

    // {WRITEENABLE, JUMP, BRANCH_TAKEN, ILLEGAL, BUSY, INSTR_READY}
    function automatic logic [5:0] strb_now();
        return {bus.WRITEENABLE, bus.JUMP, bus.BRANCH_TAKEN, bus.ILLEGAL,
                bus.BUSY, bus.INSTR_READY};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr);
        bus.INSTR_VALID = 1'b1;
        bus.INSTRUCTION = instr;
        step();
        bus.INSTR_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.INSTR_VALID = 1'b1;
        bus.INSTRUCTION = 32'h02_01_02_03;
        step();
        step();
        checks++;
        if (ctrl_now() !== 22'd0) $display("FAIL reset_ctrl: got %h expected 0", ctrl_now());
        else passes++;
        checks++;
        if (strb_now() !== 6'b000001) $display("FAIL reset_strobes: got %b expected 000001", strb_now());
        else passes++;
        RESET = 1'b0;
        bus.INSTR_VALID = 1'b0;
        step();
        checks++;
        if (strb_now() !== 6'b000001) $display("FAIL reset_no_accept: got %b expected 000001", strb_now());
        else passes++;
    endtask

    task automatic test_add();
        exp_t e;
        sb.push_back('{ctrl: {3'b001, 3'd2, 3'd3, 3'd1, 8'h03, 1'b0, 1'b0},
                       res: 4'b1000, lat: 1, name: "add"});
        checks++;
        if (bus.INSTR_READY !== 1'b1) $display("FAIL add_ready_before: got %b expected 1", bus.INSTR_READY);
        else passes++;
        issue(32'h02_01_02_03);
        e = sb.pop_front();
        for (int c = 1; c <= e.lat + 1; c++) begin
            checks++;
            if (ctrl_now() !== e.ctrl) $display("FAIL %s_ctrl c%0d: got %h expected %h", e.name, c, ctrl_now(), e.ctrl);
            else passes++;
            checks++;
            if (strb_now() !== ((c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010))
                $display("FAIL %s_strobes c%0d: got %b expected %b", e.name, c, strb_now(),
                         (c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010);
            else passes++;
            step();
        end
        checks++;
        if (strb_now() !== 6'b000001) $display("FAIL add_ready_after: got %b expected 000001", strb_now());
        else passes++;
    endtask

    task automatic test_mult();
        exp_t e;
        sb.push_back('{ctrl: {3'b111, 3'd1, 3'd2, 3'd4, 8'h02, 1'b0, 1'b0},
                       res: 4'b1000, lat: 3, name: "mult"});
        issue(32'h08_04_01_02);
        e = sb.pop_front();
        for (int c = 1; c <= e.lat + 1; c++) begin
            // An ADD offered while busy must be ignored
            bus.INSTR_VALID = (c <= e.lat);
            bus.INSTRUCTION = 32'h02_07_07_07;
            checks++;
            if (ctrl_now() !== e.ctrl) $display("FAIL %s_ctrl c%0d: got %h expected %h", e.name, c, ctrl_now(), e.ctrl);
            else passes++;
            checks++;
            if (strb_now() !== ((c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010))
                $display("FAIL %s_strobes c%0d: got %b expected %b", e.name, c, strb_now(),
                         (c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010);
            else passes++;
            step();
        end
        bus.INSTR_VALID = 1'b0;
        checks++;
        if (strb_now() !== 6'b000001) $display("FAIL mult_idle_after: got %b expected 000001", strb_now());
        else passes++;
        checks++;
        if (ctrl_now() !== e.ctrl) $display("FAIL mult_no_accept_ctrl: got %h expected %h", ctrl_now(), e.ctrl);
        else passes++;
    endtask

    task automatic test_branch();
        logic [7:0] ops [4]   = '{8'h07, 8'h07, 8'h0C, 8'h0C};
        logic       zeros [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       taken [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{ctrl: {3'b001, 3'd1, 3'd2, 3'd6, 8'hFE, 1'b0, 1'b1},
                           res: {2'b00, taken[k], 1'b0}, lat: 1, name: $sformatf("branch%0d", k)});
            issue({ops[k], 8'hFE, 8'h01, 8'h02});
            e = sb.pop_front();
            for (int c = 1; c <= e.lat + 1; c++) begin
                // ZERO only matters in the resolve cycle; drive the opposite value before it
                bus.ZERO = (c == e.lat + 1) ? zeros[k] : ~zeros[k];
                #1;
                checks++;
                if (ctrl_now() !== e.ctrl) $display("FAIL %s_ctrl c%0d: got %h expected %h", e.name, c, ctrl_now(), e.ctrl);
                else passes++;
                checks++;
                if (strb_now() !== ((c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010))
                    $display("FAIL %s_strobes c%0d: got %b expected %b", e.name, c, strb_now(),
                             (c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010);
                else passes++;
                step();
            end
            bus.ZERO = 1'b0;
        end
    endtask

    task automatic test_jump();
        exp_t e;
        sb.push_back('{ctrl: {3'b000, 3'd0, 3'd0, 3'd3, 8'h40, 1'b0, 1'b0},
                       res: 4'b0100, lat: 1, name: "jump"});
        issue(32'h06_03_00_40);
        e = sb.pop_front();
        for (int c = 1; c <= e.lat + 1; c++) begin
            checks++;
            if (ctrl_now() !== e.ctrl) $display("FAIL %s_ctrl c%0d: got %h expected %h", e.name, c, ctrl_now(), e.ctrl);
            else passes++;
            checks++;
            if (strb_now() !== ((c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010))
                $display("FAIL %s_strobes c%0d: got %b expected %b", e.name, c, strb_now(),
                         (c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010);
            else passes++;
            step();
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back('{ctrl: 22'd0, res: 4'b0001, lat: 0, name: "illegal"});
        issue(32'hFF_01_02_03);
        e = sb.pop_front();
        checks++;
        if (strb_now() !== {e.res, 2'b10}) $display("FAIL illegal_strobes: got %b expected %b", strb_now(), {e.res, 2'b10});
        else passes++;
        checks++;
        if ({bus.ALUOP, bus.IMM_SEL, bus.NEG_SEL} !== 5'b0)
            $display("FAIL illegal_ctrl: got %b expected 00000", {bus.ALUOP, bus.IMM_SEL, bus.NEG_SEL});
        else passes++;
        step();
        checks++;
        if (strb_now() !== 6'b000001) $display("FAIL illegal_ready: got %b expected 000001", strb_now());
        else passes++;
        sb.push_back('{ctrl: {3'b000, 3'd0, 3'd7, 3'd5, 8'h7F, 1'b1, 1'b0},
                       res: 4'b1000, lat: 1, name: "loadi"});
        issue(32'h00_05_00_7F);
        e = sb.pop_front();
        for (int c = 1; c <= e.lat + 1; c++) begin
            checks++;
            if (ctrl_now() !== e.ctrl) $display("FAIL %s_ctrl c%0d: got %h expected %h", e.name, c, ctrl_now(), e.ctrl);
            else passes++;
            checks++;
            if (strb_now() !== ((c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010))
                $display("FAIL %s_strobes c%0d: got %b expected %b", e.name, c, strb_now(),
                         (c == e.lat + 1) ? {e.res, 2'b10} : 6'b000010);
            else passes++;
            step();
        end
    endtask

    task automatic test_reset_abort();
        sb.push_back('{ctrl: {3'b100, 3'd3, 3'd4, 3'd2, 8'h04, 1'b1, 1'b0},
                       res: 4'b1000, lat: 2, name: "sll"});
        issue(32'h09_02_03_04);
        checks++;
        if (ctrl_now() !== sb[0].ctrl) $display("FAIL sll_ctrl: got %h expected %h", ctrl_now(), sb[0].ctrl);
        else passes++;
        step();
        RESET = 1'b1;
        #1;
        checks++;
        if (bus.WRITEENABLE !== 1'b0) $display("FAIL sll_abort_exec_we: got %b expected 0", bus.WRITEENABLE);
        else passes++;
        step();
        void'(sb.pop_front());
        checks++;
        if (ctrl_now() !== 22'd0) $display("FAIL sll_abort_ctrl: got %h expected 0", ctrl_now());
        else passes++;
        checks++;
        if (strb_now() !== 6'b000001) $display("FAIL sll_abort_strobes: got %b expected 000001", strb_now());
        else passes++;
        RESET = 1'b0;
        step();
        checks++;
        if (strb_now() !== 6'b000001) $display("FAIL sll_after_release: got %b expected 000001", strb_now());
        else passes++;

        // Reset landing in the resolve cycle must suppress the write strobe
        issue(32'h02_01_02_03);
        step();
        checks++;
        if (bus.WRITEENABLE !== 1'b1) $display("FAIL resolve_we: got %b expected 1", bus.WRITEENABLE);
        else passes++;
        RESET = 1'b1;
        #1;
        checks++;
        if (bus.WRITEENABLE !== 1'b0) $display("FAIL resolve_reset_we: got %b expected 0", bus.WRITEENABLE);
        else passes++;
        step();
        RESET = 1'b0;
        step();
        checks++;
        if (strb_now() !== 6'b000001) $display("FAIL resolve_reset_idle: got %b expected 000001", strb_now());
        else passes++;
    endtask

    initial begin
        bus.INSTR_VALID = 1'b0;
        bus.INSTRUCTION = 32'd0;
        bus.ZERO        = 1'b0;
        #1;
        test_reset();
        test_add();
        test_mult();
        test_branch();
        test_jump();
        test_back_to_back();
        test_reset_abort();
        checks++;
        if (sb.size() !== 0) $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
